// File: rtl/vid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vid_pkg                                                      |
// | Description : Shared types, luma constants and {R,B,G} slice helpers.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package vid_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_INV    = 2'd3
  } mode_t;

  localparam int c_coef_r     = 77;
  localparam int c_coef_g     = 150;
  localparam int c_coef_b     = 29;
  localparam int c_luma_shift = 8;
  // Helpers operate on a pixel zero-extended to this width (channels up to 32 bits).
  localparam int c_px_max_w   = 96;

  function automatic logic [31:0] px_r(input logic [c_px_max_w-1:0] px, input int dw);
    return 32'((px >> (2 * dw)) & ((96'd1 << dw) - 96'd1));
  endfunction

  function automatic logic [31:0] px_b(input logic [c_px_max_w-1:0] px, input int dw);
    return 32'((px >> dw) & ((96'd1 << dw) - 96'd1));
  endfunction

  function automatic logic [31:0] px_g(input logic [c_px_max_w-1:0] px, input int dw);
    return 32'(px & ((96'd1 << dw) - 96'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vid_luma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vid_luma                                                     |
// | Description : Pipeline stages 1-2: registered luma with data/sync carry.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vid_luma
  import vid_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3*DW-1:0] data_i,
  input  logic            vde_i,
  input  logic            hsync_i,
  input  logic            vsync_i,
  output logic [DW-1:0]   y_o,
  output logic [3*DW-1:0] data_o,
  output logic            vde_o,
  output logic            hsync_o,
  output logic            vsync_o
);

  localparam int c_pw = DW + 8;
  localparam int c_sw = DW + 10;

  logic [DW-1:0]   w_r, w_g, w_b;
  logic [c_sw-1:0] w_sum;
  logic [DW-1:0]   w_y;

  logic [c_pw-1:0] r_p_r, r_p_g, r_p_b;
  logic [3*DW-1:0] r_d1, r_d2;
  logic            r_vde1, r_hs1, r_vs1;
  logic            r_vde2, r_hs2, r_vs2;
  logic [DW-1:0]   r_y2;

  assign w_r = DW'(px_r(c_px_max_w'(data_i), DW));
  assign w_g = DW'(px_g(c_px_max_w'(data_i), DW));
  assign w_b = DW'(px_b(c_px_max_w'(data_i), DW));

  // Coefficients sum to 256, so the shifted sum always fits in DW bits.
  assign w_sum = c_sw'(r_p_r) + c_sw'(r_p_g) + c_sw'(r_p_b);
  assign w_y   = DW'(w_sum >> c_luma_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_r  <= '0;
      r_p_g  <= '0;
      r_p_b  <= '0;
      r_d1   <= '0;
      r_vde1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_y2   <= '0;
      r_d2   <= '0;
      r_vde2 <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_p_r  <= c_pw'(c_coef_r) * c_pw'(w_r);
      r_p_g  <= c_pw'(c_coef_g) * c_pw'(w_g);
      r_p_b  <= c_pw'(c_coef_b) * c_pw'(w_b);
      r_d1   <= data_i;
      r_vde1 <= vde_i;
      r_hs1  <= hsync_i;
      r_vs1  <= vsync_i;
      r_y2   <= w_y;
      r_d2   <= r_d1;
      r_vde2 <= r_vde1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  assign y_o     = r_y2;
  assign data_o  = r_d2;
  assign vde_o   = r_vde2;
  assign hsync_o = r_hs2;
  assign vsync_o = r_vs2;

endmodule
`default_nettype wire

// File: rtl/vid_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vid_pipe                                                     |
// | Description : Frame-synchronous pixel stage with mode mux and statistics.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vid_pipe
  import vid_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CNT_W  = 22,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3*DW-1:0]   data_i,
  input  logic              vde_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [1:0]        mode_i,
  input  logic [DW-1:0]     thresh_i,
  output logic [3*DW-1:0]   data_o,
  output logic              vde_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [1:0]        mode_o,
  output logic              stat_vld_o,
  output logic [CNT_W-1:0]  hot_cnt_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  logic [DW-1:0]   w_y2;
  logic [3*DW-1:0] w_d2;
  logic            w_vde2, w_hs2, w_vs2;
  logic            w_boundary;
  logic            w_hot2;
  logic            w_sat;
  logic [3*DW-1:0] w_px3;

  logic              r_vs2_d;
  mode_t             r_mode;
  logic [DW-1:0]     r_thresh;
  logic [CNT_W-1:0]  r_hot_run;
  logic [CNT_W-1:0]  r_hot_cnt;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_stat_vld;
  logic [3*DW-1:0]   r_data3;
  logic              r_vde3, r_hs3, r_vs3;

  vid_luma #(.DW(DW)) u_luma (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .vde_i   (vde_i),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .y_o     (w_y2),
    .data_o  (w_d2),
    .vde_o   (w_vde2),
    .hsync_o (w_hs2),
    .vsync_o (w_vs2)
  );

  assign w_boundary = w_vs2 & ~r_vs2_d;
  assign w_hot2     = w_vde2 & (w_y2 >= r_thresh);
  assign w_sat      = &r_hot_run;

  always_comb begin
    w_px3 = '0;
    if (w_vde2) begin
      case (r_mode)
        MODE_PASS:   w_px3 = w_d2;
        MODE_GRAY:   w_px3 = {3{w_y2}};
        MODE_THRESH: w_px3 = {(3*DW){w_hot2}};
        MODE_INV:    w_px3 = ~w_d2;
        default:     w_px3 = w_d2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs2_d     <= 1'b0;
      r_mode      <= MODE_PASS;
      r_thresh    <= '0;
      r_hot_run   <= '0;
      r_hot_cnt   <= '0;
      r_frame_cnt <= '0;
      r_stat_vld  <= 1'b0;
      r_data3     <= '0;
      r_vde3      <= 1'b0;
      r_hs3       <= 1'b0;
      r_vs3       <= 1'b0;
    end else begin
      r_data3    <= w_px3;
      r_vde3     <= w_vde2;
      r_hs3      <= w_hs2;
      r_vs3      <= w_vs2;
      r_vs2_d    <= w_vs2;
      r_stat_vld <= w_boundary;
      // The boundary pixel belongs to the new frame, so it seeds the fresh count.
      if (w_boundary) begin
        r_mode      <= mode_t'(mode_i);
        r_thresh    <= thresh_i;
        r_hot_cnt   <= r_hot_run;
        r_hot_run   <= CNT_W'(w_hot2);
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end else if (w_hot2 && !w_sat) begin
        r_hot_run <= r_hot_run + CNT_W'(1);
      end
    end
  end

  assign data_o      = r_data3;
  assign vde_o       = r_vde3;
  assign hsync_o     = r_hs3;
  assign vsync_o     = r_vs3;
  assign mode_o      = r_mode;
  assign stat_vld_o  = r_stat_vld;
  assign hot_cnt_o   = r_hot_cnt;
  assign frame_cnt_o = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vid_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vid_pipe                                                  |
// | Description : Scoreboard bench for vid_pipe (full and 4-bit counter).      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vid_pipe;

  typedef struct {
    int          due;
    logic [23:0] d;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
  } vexp_t;

  typedef struct {
    int due;
    int hot;
    int frame;
  } sexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data_i = '0;
  logic        vde_i = 1'b0;
  logic        hsync_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  thresh_i = 8'd0;

  logic [23:0] data_o;
  logic        vde_o, hsync_o, vsync_o, stat_vld_o;
  logic [1:0]  mode_o;
  logic [21:0] hot_cnt_o;
  logic [15:0] frame_cnt_o;

  logic [23:0] s_data_o;
  logic        s_vde_o, s_hsync_o, s_vsync_o, s_stat_vld_o;
  logic [1:0]  s_mode_o;
  logic [3:0]  s_hot_cnt_o;
  logic [15:0] s_frame_cnt_o;

  vexp_t vq[$];
  sexp_t sq[$];
  sexp_t sq_sat[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int zlo = -1;
  int zhi = -1;

  int         m_hot = 0;
  int         m_frame = 0;
  logic [1:0] m_mode = 2'd0;
  logic       m_prev_vs = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vid_pipe #(.DW(8), .CNT_W(22), .FCNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .vde_i(vde_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .mode_i(mode_i), .thresh_i(thresh_i), .data_o(data_o),
    .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .mode_o(mode_o),
    .stat_vld_o(stat_vld_o), .hot_cnt_o(hot_cnt_o), .frame_cnt_o(frame_cnt_o)
  );

  vid_pipe #(.DW(8), .CNT_W(4), .FCNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .data_i(data_i), .vde_i(vde_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .mode_i(mode_i), .thresh_i(thresh_i), .data_o(s_data_o),
    .vde_o(s_vde_o), .hsync_o(s_hsync_o), .vsync_o(s_vsync_o), .mode_o(s_mode_o),
    .stat_vld_o(s_stat_vld_o), .hot_cnt_o(s_hot_cnt_o), .frame_cnt_o(s_frame_cnt_o)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_zero(input int due);
    vexp_t e;
    e.due = due; e.d = '0; e.vde = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.mode = 2'd0;
    vq.push_back(e);
  endtask

  // One pixel per call; expected output and hot flag are supplied by the caller.
  task automatic drive(input logic [23:0] d, input logic v, input logic h, input logic s,
                       input logic [23:0] exp_d, input logic hot);
    vexp_t e;
    sexp_t st;
    @(posedge clk); #1;
    rst = 1'b0; data_i = d; vde_i = v; hsync_i = h; vsync_i = s;
    if (s && !m_prev_vs) begin
      st.due = cyc + 3; st.hot = m_hot; st.frame = (m_frame + 1) % 65536;
      sq.push_back(st);
      st.hot = (m_hot > 15) ? 15 : m_hot;
      sq_sat.push_back(st);
      m_frame = m_frame + 1;
      m_hot   = int'(hot);
      m_mode  = mode_i;
    end else begin
      m_hot = m_hot + int'(hot);
    end
    m_prev_vs = s;
    e.due = cyc + 3; e.d = exp_d; e.vde = v; e.hs = h; e.vs = s; e.mode = m_mode;
    vq.push_back(e);
  endtask

  task automatic vpulse();
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic reset_mid();
    int n;
    @(posedge clk); #1;
    rst = 1'b1; data_i = '0; vde_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; mode_i = 2'd0;
    n = cyc;
    while (vq.size() > 0 && vq[vq.size()-1].due > n) void'(vq.pop_back());
    for (int k = 1; k <= 3; k++) push_zero(n + k);
    m_hot = 0; m_frame = 0; m_mode = 2'd0; m_prev_vs = 1'b0;
    zlo = n + 1; zhi = n + 1;
  endtask

  always @(negedge clk) begin
    vexp_t e;
    sexp_t s;
    if (vq.size() > 0 && vq[0].due == cyc) begin
      e = vq.pop_front();
      chk("data_o",  data_o,  e.d);
      chk("vde_o",   vde_o,   e.vde);
      chk("hsync_o", hsync_o, e.hs);
      chk("vsync_o", vsync_o, e.vs);
      chk("mode_o",  mode_o,  e.mode);
    end
    if (sq.size() > 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      chk("stat_vld_o",  stat_vld_o,  1);
      chk("hot_cnt_o",   hot_cnt_o,   s.hot);
      chk("frame_cnt_o", frame_cnt_o, s.frame);
    end else if (stat_vld_o) begin
      chk("stat_vld_o_spurious", stat_vld_o, 0);
    end
    if (sq_sat.size() > 0 && sq_sat[0].due == cyc) begin
      s = sq_sat.pop_front();
      chk("sat_stat_vld_o",  s_stat_vld_o,  1);
      chk("sat_hot_cnt_o",   s_hot_cnt_o,   s.hot);
      chk("sat_frame_cnt_o", s_frame_cnt_o, s.frame);
    end else if (s_stat_vld_o) begin
      chk("sat_stat_vld_o_spurious", s_stat_vld_o, 0);
    end
    if (cyc >= zlo && cyc <= zhi) begin
      chk("rst_hot_cnt_o",   hot_cnt_o,   0);
      chk("rst_frame_cnt_o", frame_cnt_o, 0);
      chk("rst_stat_vld_o",  stat_vld_o,  0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    push_zero(3);
    push_zero(4);
    zlo = 3; zhi = 4;
    repeat (4) @(posedge clk);

    // Passthrough ramp with hsync pattern and vde gaps (all luma well below 128).
    thresh_i = 8'd128; mode_i = 2'd0;
    vpulse();
    for (int i = 0; i < 16; i++) begin
      logic [23:0] d;
      logic        v;
      logic [3:0]  ib;
      ib = 4'(i);
      d  = {8'(i), 8'(2 * i), 8'(3 * i)};
      v  = (i % 4) != 3;
      drive(d, v, ib[2], 1'b0, v ? d : 24'h0, 1'b0);
    end

    // Gray
    mode_i = 2'd1;
    vpulse();
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 24'h4C4C4C, 1'b0);
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b1);
    drive(24'h000000, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0);
    drive(24'h0000FF, 1'b1, 1'b1, 1'b0, 24'h959595, 1'b1);
    drive(24'h00FF00, 1'b1, 1'b1, 1'b0, 24'h1C1C1C, 1'b0);
    drive(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);

    // Threshold at 128: 40 pixels of Y=200, 60 of Y=50
    mode_i = 2'd2;
    vpulse();
    for (int i = 0; i < 100; i++) begin
      if ((i % 5) < 2) drive(24'hC8C8C8, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b1);
      else             drive(24'h323232, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0);
    end

    // Mode request 0 -> 3 mid-frame only lands at the next boundary
    mode_i = 2'd0;
    vpulse();
    for (int i = 0; i < 4; i++) drive(24'h123456, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b0);
    mode_i = 2'd3;
    for (int i = 0; i < 4; i++) drive(24'h123456, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b0);
    vpulse();
    for (int i = 0; i < 4; i++) drive(24'h123456, 1'b1, 1'b0, 1'b0, 24'hEDCBA9, 1'b0);
    // 20 hot pixels saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1);
    vpulse();

    // Hot pixels before a mid-frame reset are discarded
    for (int i = 0; i < 5; i++) drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1);
    reset_mid();
    // Active threshold is 0 after reset, so every active pixel is hot
    for (int i = 0; i < 3; i++) drive(24'h123456, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b1);
    vpulse();

    // Back-to-back vsync pulses one cycle apart
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    for (int i = 0; i < 8; i++) drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("video_queue_left",   vq.size(),     0);
    chk("stat_queue_left",    sq.size(),     0);
    chk("satstat_queue_left", sq_sat.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vid_pipe.md
# vid_pipe

Parametrised, frame-synchronous pixel-processing stage for the pixel-clock domain, placed between the DVI receiver output and the VGA encoder input. It supersedes the fixed single-function image stage. It adds run-time mode selection (passthrough, grayscale, threshold, invert), applied only at frame boundaries. It also emits per-frame statistics (frame count, count of above-threshold pixels) for the resistor-band detector logic. Video data and sync signals leave with identical, fixed latency.

## Interface
Parameters:
- DW, 8, bits per colour channel
- CNT_W, 22, width of hot-pixel counter (≥ log2 of active pixels per frame)
- FCNT_W, 16, width of frame counter

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous and active-high
- data_i  in  3*DW  pixel, packed {R, B, G} (R in MSBs), matching receiver order
- vde_i  in  1  active-video flag
- hsync_i  in  1  horizontal sync
- vsync_i  in  1  vertical sync, active-high
- mode_i  in  2  requested mode: 0 pass, 1 gray, 2 thresh, 3 invert
- thresh_i  in  DW  luma threshold
- data_o  out  3*DW  processed pixel, same packing
- vde_o, hsync_o, vsync_o  out  1 each  delayed syncs
- mode_o  out  2  mode currently in effect
- stat_vld_o  out  1  one-cycle pulse, statistics valid
- hot_cnt_o  out  CNT_W  hot pixels in the frame just ended
- frame_cnt_o  out  FCNT_W  frames completed, wraps

## Operation
- Luma: Y = (77·R + 150·G + 29·B) >> 8. Products are DW+8 bits and the sum is DW+10 bits. Y always fits DW bits (coefficients sum to 256).
- A pixel is hot when vde is high and Y ≥ thresh (active threshold, not thresh_i directly).
- Output per active mode:
  - pass: data unchanged.
  - gray: all three channels = Y.
  - thresh: all channels = all-ones if Y ≥ thresh, else 0.
  - invert: each channel bitwise complemented.
- When vde is low at stage 3, data_o = 0 regardless of mode.
- Frame boundary = rising edge of vsync at stage 2 (vs2 high, previous vs2 low). On that cycle:
  - mode_i latches into the active mode; thresh_i latches into the active threshold.
  - hot_cnt_o is loaded with the running counter and stat_vld_o pulses.
  - The running counter clears to 0, or to 1 if the stage-2 pixel on that cycle is hot.
  - frame_cnt_o increments and wraps at 2^FCNT_W.
- mode_i and thresh_i changes between boundaries have no effect.
- The running counter saturates at 2^CNT_W−1 and does not wrap.
- Hot counting always runs, in every mode, against the active threshold.

## Timing
- Three pipeline stages:
  - S1 registers the products and input data.
  - S2 registers Y and the data.
  - S3 registers the mode mux into the outputs.
- data/vde/hsync/vsync latency is exactly 3 cycles, equal for all signals in all modes.
- A new mode takes effect on the first pixel entering S3 the cycle after the boundary cycle.
- stat_vld_o asserts the cycle after the boundary cycle (registered) and is high for 1 cycle. hot_cnt_o and frame_cnt_o update on that same cycle and hold until the next pulse.
- Reset values:
  - All outputs 0; mode_o = 0 (pass); active threshold = 0.
  - Counters 0; all pipeline registers 0; vs2 history = 0.
- Because the history resets to 0, a frame whose vsync is high at reset release produces a boundary on the first cycle vs2 is seen high.
- Reset mid-frame discards all in-flight pixels and partial counts. No stat_vld_o pulse results from reset.
- Back-to-back vsync pulses one cycle apart each produce a boundary.

## Structure
- Package vid_pkg holds:
  - mode enum (MODE_PASS, MODE_GRAY, MODE_THRESH, MODE_INV)
  - luma coefficient constants (77, 150, 29) and shift (8)
  - the {R,B,G} field-slice helper functions
- Sub-module vid_luma (S1–S2): computes registered Y from registered data, with data passthrough. The top of vid_pipe holds the boundary detect, mode/threshold latches, statistics and S3.

## Test plan
- Passthrough: mode 0, ramp data with sync patterns -> data_o/vde_o/hsync_o/vsync_o equal the inputs delayed exactly 3 cycles.
- Gray, DW=8: {R,B,G} = {255,0,0} -> each channel 76; white -> 255; black -> 0.
- Threshold and counting:
  - thresh 128, frame of 100 active pixels, 40 with Y=200 and 60 with Y=50 -> outputs only 0xFFFFFF/0x000000.
  - Next boundary: stat_vld_o one cycle, hot_cnt_o = 40, frame_cnt_o incremented by 1.
- Mode change mid-frame 0→3 -> output unchanged until the next vsync rising edge, then every channel complemented; mode_o changes the cycle after the boundary.
- Saturation, CNT_W=4: 20 hot pixels in a frame -> hot_cnt_o = 15.
- Reset mid-frame: rst high for 1 cycle -> all outputs 0 on the next cycle; the next boundary reports only hot pixels after reset; frame_cnt_o = 1.
